// File: rtl/ysyx_25030077_ifu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25030077_ifu_pkg
// Shared definitions for the IFU fetch queue:
//   - AXI_RESP_OKAY   : the only response code treated as a successful fetch
//   - DEFAULT_*       : default parameter values of the fetch queue
//   - fetch_pkt_t     : {pc, data, err} packet handed to the decoder
// ---------------------------------------------------------------------------
package ysyx_25030077_ifu_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int DEFAULT_ADDR_W  = 32;
  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_MAX_OUT = 2;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] pc;
    logic [DEFAULT_DATA_W-1:0] data;
    logic                      err;
  } fetch_pkt_t;

endpackage

// File: rtl/ysyx_25030077_sync_fifo.sv
// ---------------------------------------------------------------------------
// ysyx_25030077_sync_fifo
// Small circular-buffer FIFO with a combinational head (deq_data is valid in
// the same cycle as deq_valid). Pointers are one bit wider than the index so
// full/empty can be told apart without a separate counter.
// Ports:
//   clock, reset (async, active-low)
//   clear                 : synchronous flush of both pointers (wins over enq/deq)
//   enq_valid/enq_ready   : write handshake, enq_data
//   deq_valid/deq_ready   : read handshake, deq_data = current head
//   count                 : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ysyx_25030077_sync_fifo
  import ysyx_25030077_ifu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ADDR_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [WIDTH-1:0]         enq_data,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [WIDTH-1:0]         deq_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? (PW - 1) : 1;
  // Pointer XOR pattern meaning "same slot, one lap apart".
  localparam logic [PW-1:0] FULL_XOR = PW'(1 << (PW - 1));

  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             enq_fire;
  logic             deq_fire;

  generate
    if (DEPTH > 1) begin : g_idx
      assign wr_idx = wr_ptr_reg[IW-1:0];
      assign rd_idx = rd_ptr_reg[IW-1:0];
    end else begin : g_idx_single
      // Single slot: the pointer is just the lap bit.
      assign wr_idx = '0;
      assign rd_idx = '0;
    end
  endgenerate

  assign full      = (wr_ptr_reg ^ rd_ptr_reg) == FULL_XOR;
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign enq_fire  = enq_valid && !full && !clear;
  assign deq_fire  = deq_valid && deq_ready && !clear;
  assign deq_data  = mem[rd_idx];
  assign count     = wr_ptr_reg - rd_ptr_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (enq_fire) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (deq_fire) rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clock) begin
    if (enq_fire) mem[wr_idx] <= enq_data;
  end

endmodule

// File: rtl/ysyx_25030077_ifu_fetch_q.sv
// ---------------------------------------------------------------------------
// ysyx_25030077_ifu_fetch_q
// Instruction-fetch front end: queues fetch PCs, issues them on the AR
// channel with up to MAX_OUT reads in flight, pairs in-order R responses with
// their PCs and delivers {pc, inst, err} to the decoder. io_flush (redirect)
// empties the request queue and discards responses of reads still in flight.
// Ports:
//   clock, reset (async, active-low)
//   io_rd_Req_*  : fetch request in (PC)
//   io_flush     : redirect pulse
//   io_ar_*      : read address out
//   io_r_*       : read data in (data, resp)
//   io_inst_*    : instruction out to decoder (pc, data, err)
//   io_count     : request FIFO occupancy
// Optional feature macro IFU_PERF_CNT_EN adds io_perf_fetch, io_perf_stall
// and io_perf_drop (32-bit wrapping event counters).
// ---------------------------------------------------------------------------
module ysyx_25030077_ifu_fetch_q
  import ysyx_25030077_ifu_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int MAX_OUT = DEFAULT_MAX_OUT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_rd_Req_valid,
  output logic                     io_rd_Req_ready,
  input  logic [ADDR_W-1:0]        io_rd_Req_bits_addr,
  input  logic                     io_flush,
  output logic                     io_ar_valid,
  input  logic                     io_ar_ready,
  output logic [ADDR_W-1:0]        io_ar_bits_addr,
  input  logic                     io_r_valid,
  output logic                     io_r_ready,
  input  logic [DATA_W-1:0]        io_r_bits_data,
  input  logic [1:0]               io_r_bits_resp,
  output logic                     io_inst_valid,
  input  logic                     io_inst_ready,
  output logic [ADDR_W-1:0]        io_inst_bits_pc,
  output logic [DATA_W-1:0]        io_inst_bits_data,
  output logic                     io_inst_bits_err,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]              io_perf_fetch,
  output logic [31:0]              io_perf_stall,
  output logic [31:0]              io_perf_drop,
`endif
  output logic [$clog2(DEPTH):0]   io_count
);

  localparam int OW = $clog2(MAX_OUT) + 1;
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);

  logic              req_enq_valid;
  logic              req_enq_ready;
  logic              req_deq_valid;
  logic              req_deq_ready;
  logic [ADDR_W-1:0] req_head;

  logic              pc_enq_ready;
  logic              pc_deq_valid;
  logic              pc_deq_ready;
  logic [ADDR_W-1:0] pc_head;
  logic [OW-1:0]     outstanding;

  logic [OW-1:0]     drop_cnt_reg;
  logic [OW-1:0]     drop_cnt_next;

  logic              slot_free;
  logic              dropping;
  logic              ar_fire;
  logic              r_fire;

  // ---------------- request FIFO ----------------
  assign req_enq_valid = io_rd_Req_valid && !io_flush;

  ysyx_25030077_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (io_flush),
    .enq_valid (req_enq_valid),
    .enq_ready (req_enq_ready),
    .enq_data  (io_rd_Req_bits_addr),
    .deq_valid (req_deq_valid),
    .deq_ready (req_deq_ready),
    .deq_data  (req_head),
    .count     (io_count)
  );

  // Ready depends only on registered fullness, so a pop in the same cycle
  // never lets a new request through a full queue.
  assign io_rd_Req_ready = req_enq_ready && !io_flush;

  // ---------------- AR issue ----------------
  // pc_enq_ready is implied by outstanding < MAX_OUT; kept as a guard so the
  // tracking FIFO can never overflow.
  assign slot_free       = (outstanding < MAX_OUT_C) && pc_enq_ready;
  assign io_ar_valid     = req_deq_valid && slot_free && !io_flush;
  assign io_ar_bits_addr = req_head;
  assign req_deq_ready   = io_ar_ready && slot_free && !io_flush;
  assign ar_fire         = io_ar_valid && io_ar_ready;

  // ---------------- PC tracking FIFO ----------------
  // Never cleared: across a flush it keeps PCs aligned with the responses
  // still to come. Its occupancy is the outstanding-read count (+1 per AR
  // handshake, -1 per R handshake, unchanged when both happen).
  assign pc_deq_ready = io_r_valid && io_r_ready;

  ysyx_25030077_sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUT)
  ) u_pc_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (1'b0),
    .enq_valid (ar_fire),
    .enq_ready (pc_enq_ready),
    .enq_data  (req_head),
    .deq_valid (pc_deq_valid),
    .deq_ready (pc_deq_ready),
    .deq_data  (pc_head),
    .count     (outstanding)
  );

  // ---------------- R path ----------------
  assign dropping          = (drop_cnt_reg != '0);
  assign io_r_ready        = dropping ? 1'b1 : io_inst_ready;
  assign r_fire            = io_r_valid && io_r_ready && pc_deq_valid;
  assign io_inst_valid     = io_r_valid && !dropping;
  assign io_inst_bits_pc   = pc_head;
  assign io_inst_bits_data = io_r_bits_data;
  assign io_inst_bits_err  = (io_r_bits_resp != AXI_RESP_OKAY);

  // A response accepted in the flush cycle itself is not one to drop later.
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (io_flush) begin
      drop_cnt_next = outstanding - OW'(r_fire);
    end else if (r_fire && dropping) begin
      drop_cnt_next = drop_cnt_reg - OW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt_reg <= '0;
    end else begin
      drop_cnt_reg <= drop_cnt_next;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_reg;
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_drop_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetch_reg <= '0;
      perf_stall_reg <= '0;
      perf_drop_reg  <= '0;
    end else begin
      if (io_inst_valid && io_inst_ready) perf_fetch_reg <= perf_fetch_reg + 32'd1;
      if (io_ar_valid && !io_ar_ready)    perf_stall_reg <= perf_stall_reg + 32'd1;
      if (r_fire && dropping)             perf_drop_reg  <= perf_drop_reg + 32'd1;
    end
  end

  assign io_perf_fetch = perf_fetch_reg;
  assign io_perf_stall = perf_stall_reg;
  assign io_perf_drop  = perf_drop_reg;
`endif

endmodule

// File: tb/tb_ysyx_25030077_ifu_fetch_q.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25030077_ifu_fetch_q
// Cycle-by-cycle directed vectors for the fetch queue (default parameters:
// DEPTH = 4, MAX_OUT = 2), followed by a hand-written stall/reset sequence.
// Each vector drives inputs after a rising edge and compares outputs on the
// falling edge. IFU_PERF_CNT_EN also enables the perf counter checks.
// ---------------------------------------------------------------------------
module tb_ysyx_25030077_ifu_fetch_q;

  localparam logic [31:0] A = 32'h8000_0000;
  localparam int NV = 36;

  logic        clock;
  logic        reset;
  logic        io_rd_Req_valid;
  logic        io_rd_Req_ready;
  logic [31:0] io_rd_Req_bits_addr;
  logic        io_flush;
  logic        io_ar_valid;
  logic        io_ar_ready;
  logic [31:0] io_ar_bits_addr;
  logic        io_r_valid;
  logic        io_r_ready;
  logic [31:0] io_r_bits_data;
  logic [1:0]  io_r_bits_resp;
  logic        io_inst_valid;
  logic        io_inst_ready;
  logic [31:0] io_inst_bits_pc;
  logic [31:0] io_inst_bits_data;
  logic        io_inst_bits_err;
  logic [2:0]  io_count;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] io_perf_fetch;
  logic [31:0] io_perf_stall;
  logic [31:0] io_perf_drop;
`endif

  ysyx_25030077_ifu_fetch_q dut (
    .clock               (clock),
    .reset               (reset),
    .io_rd_Req_valid     (io_rd_Req_valid),
    .io_rd_Req_ready     (io_rd_Req_ready),
    .io_rd_Req_bits_addr (io_rd_Req_bits_addr),
    .io_flush            (io_flush),
    .io_ar_valid         (io_ar_valid),
    .io_ar_ready         (io_ar_ready),
    .io_ar_bits_addr     (io_ar_bits_addr),
    .io_r_valid          (io_r_valid),
    .io_r_ready          (io_r_ready),
    .io_r_bits_data      (io_r_bits_data),
    .io_r_bits_resp      (io_r_bits_resp),
    .io_inst_valid       (io_inst_valid),
    .io_inst_ready       (io_inst_ready),
    .io_inst_bits_pc     (io_inst_bits_pc),
    .io_inst_bits_data   (io_inst_bits_data),
    .io_inst_bits_err    (io_inst_bits_err),
`ifdef IFU_PERF_CNT_EN
    .io_perf_fetch       (io_perf_fetch),
    .io_perf_stall       (io_perf_stall),
    .io_perf_drop        (io_perf_drop),
`endif
    .io_count            (io_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        fl;
    logic        arr;
    logic        rvld;
    logic [31:0] rd;
    logic [1:0]  resp;
    logic        ir;
    logic        e_rq;
    logic        e_arv;
    logic [31:0] e_ara;
    logic        e_rr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_data;
    logic        e_err;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs [NV];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic rv, input logic [31:0] ra, input logic fl, input logic arr,
    input logic rvld, input logic [31:0] rd, input logic [1:0] resp, input logic ir,
    input logic e_rq, input logic e_arv, input logic [31:0] e_ara, input logic e_rr,
    input logic e_iv, input logic [31:0] e_pc, input logic [31:0] e_data,
    input logic e_err, input logic [2:0] e_cnt);
    vec_t v;
    v.rv = rv; v.ra = ra; v.fl = fl; v.arr = arr;
    v.rvld = rvld; v.rd = rd; v.resp = resp; v.ir = ir;
    v.e_rq = e_rq; v.e_arv = e_arv; v.e_ara = e_ara; v.e_rr = e_rr;
    v.e_iv = e_iv; v.e_pc = e_pc; v.e_data = e_data; v.e_err = e_err; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic idle_inputs();
    io_rd_Req_valid     = 1'b0;
    io_rd_Req_bits_addr = '0;
    io_flush            = 1'b0;
    io_ar_ready         = 1'b0;
    io_r_valid          = 1'b0;
    io_r_bits_data      = '0;
    io_r_bits_resp      = '0;
    io_inst_ready       = 1'b1;
  endtask

  logic [103:0] act_pk;
  logic [103:0] exp_pk;
  int exp_fetch = 0;
  int exp_stall = 0;
  int exp_drop  = 0;
  int waited;

  initial begin
    // ---------------- vector table ----------------
    //            rv  ra       fl arr rvld rd            resp ir  rq arv ara       rr iv pc      data          err cnt
    vecs[0]  = mk(0, 0,        0, 0, 0, 0,            0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 0);
    vecs[1]  = mk(0, 0,        0, 0, 0, 0,            0, 0,   1, 0, 0,        0, 0, 0,       0,            0, 0);
    vecs[2]  = mk(1, A,        0, 1, 0, 0,            0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 0);
    vecs[3]  = mk(0, 0,        0, 1, 0, 0,            0, 1,   1, 1, A,        1, 0, 0,       0,            0, 1);
    vecs[4]  = mk(0, 0,        0, 1, 1, 32'h413,      0, 1,   1, 0, 0,        1, 1, A,       32'h413,      0, 0);
    vecs[5]  = mk(1, A+'h10,   0, 0, 0, 0,            0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 0);
    vecs[6]  = mk(1, A+'h14,   0, 0, 0, 0,            0, 1,   1, 1, A+'h10,   1, 0, 0,       0,            0, 1);
    vecs[7]  = mk(1, A+'h18,   0, 0, 0, 0,            0, 1,   1, 1, A+'h10,   1, 0, 0,       0,            0, 2);
    vecs[8]  = mk(1, A+'h1c,   0, 0, 0, 0,            0, 1,   1, 1, A+'h10,   1, 0, 0,       0,            0, 3);
    vecs[9]  = mk(1, A+'h20,   0, 0, 0, 0,            0, 1,   0, 1, A+'h10,   1, 0, 0,       0,            0, 4);
    vecs[10] = mk(1, A+'h20,   0, 1, 0, 0,            0, 1,   0, 1, A+'h10,   1, 0, 0,       0,            0, 4);
    vecs[11] = mk(0, 0,        0, 1, 0, 0,            0, 1,   1, 1, A+'h14,   1, 0, 0,       0,            0, 3);
    vecs[12] = mk(0, 0,        0, 1, 0, 0,            0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 2);
    vecs[13] = mk(0, 0,        0, 1, 0, 0,            0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 2);
    vecs[14] = mk(0, 0,        0, 1, 1, 32'h93,       0, 1,   1, 0, 0,        1, 1, A+'h10,  32'h93,       0, 2);
    vecs[15] = mk(0, 0,        0, 1, 0, 0,            0, 1,   1, 1, A+'h18,   1, 0, 0,       0,            0, 2);
    vecs[16] = mk(1, A+'h24,   0, 1, 0, 0,            0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 1);
    vecs[17] = mk(1, A+'h28,   1, 1, 0, 0,            0, 1,   0, 0, 0,        1, 0, 0,       0,            0, 2);
    vecs[18] = mk(0, 0,        0, 1, 1, 32'hdead,     0, 0,   1, 0, 0,        1, 0, 0,       0,            0, 0);
    vecs[19] = mk(1, A+'h100,  0, 1, 1, 32'hbeef,     0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 0);
    vecs[20] = mk(0, 0,        0, 1, 0, 0,            0, 1,   1, 1, A+'h100,  1, 0, 0,       0,            0, 1);
    vecs[21] = mk(0, 0,        0, 1, 1, 32'h100093,   0, 1,   1, 0, 0,        1, 1, A+'h100, 32'h100093,   0, 0);
    vecs[22] = mk(1, A+'h4,    0, 1, 0, 0,            0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 0);
    vecs[23] = mk(0, 0,        0, 1, 0, 0,            0, 1,   1, 1, A+'h4,    1, 0, 0,       0,            0, 1);
    vecs[24] = mk(0, 0,        0, 1, 1, 32'hbad,      2, 0,   1, 0, 0,        0, 1, A+'h4,   32'hbad,      1, 0);
    vecs[25] = mk(0, 0,        0, 1, 1, 32'hbad,      2, 1,   1, 0, 0,        1, 1, A+'h4,   32'hbad,      1, 0);
    vecs[26] = mk(0, 0,        0, 1, 0, 0,            0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 0);
    vecs[27] = mk(1, A+'h200,  0, 0, 0, 0,            0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 0);
    vecs[28] = mk(1, A+'h204,  0, 1, 0, 0,            0, 1,   1, 1, A+'h200,  1, 0, 0,       0,            0, 1);
    vecs[29] = mk(0, 0,        0, 1, 0, 0,            0, 1,   1, 1, A+'h204,  1, 0, 0,       0,            0, 1);
    vecs[30] = mk(0, 0,        1, 1, 1, 32'h11,       0, 1,   0, 0, 0,        1, 1, A+'h200, 32'h11,       0, 0);
    vecs[31] = mk(0, 0,        0, 1, 1, 32'h22,       0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 0);
    vecs[32] = mk(0, 0,        0, 1, 0, 0,            0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 0);
    vecs[33] = mk(1, A+'h300,  0, 1, 0, 0,            0, 1,   1, 0, 0,        1, 0, 0,       0,            0, 0);
    vecs[34] = mk(0, 0,        0, 1, 0, 0,            0, 1,   1, 1, A+'h300,  1, 0, 0,       0,            0, 1);
    vecs[35] = mk(0, 0,        0, 1, 1, 32'h33,       0, 1,   1, 0, 0,        1, 1, A+'h300, 32'h33,       0, 0);

    // ---------------- reset ----------------
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {61'd0, io_rd_Req_ready, io_ar_valid, io_inst_valid},
        {61'd0, 1'b1, 1'b0, 1'b0});
    chk("reset_count", {61'd0, io_count}, 64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      io_rd_Req_valid     = vecs[i].rv;
      io_rd_Req_bits_addr = vecs[i].ra;
      io_flush            = vecs[i].fl;
      io_ar_ready         = vecs[i].arr;
      io_r_valid          = vecs[i].rvld;
      io_r_bits_data      = vecs[i].rd;
      io_r_bits_resp      = vecs[i].resp;
      io_inst_ready       = vecs[i].ir;
      @(negedge clock);
      act_pk = {io_rd_Req_ready, io_ar_valid,
                vecs[i].e_arv ? io_ar_bits_addr : 32'd0,
                io_r_ready, io_inst_valid,
                vecs[i].e_iv ? {io_inst_bits_pc, io_inst_bits_data, io_inst_bits_err} : 65'd0,
                io_count};
      exp_pk = {vecs[i].e_rq, vecs[i].e_arv, vecs[i].e_ara, vecs[i].e_rr, vecs[i].e_iv,
                vecs[i].e_iv ? {vecs[i].e_pc, vecs[i].e_data, vecs[i].e_err} : 65'd0,
                vecs[i].e_cnt};
      checks++;
      if (act_pk !== exp_pk) begin
        errors++;
        $display("FAIL vec%0d: got %026h expected %026h", i, act_pk, exp_pk);
      end else begin
        $display("ok   vec%0d: rq=%0b arv=%0b ara=%08h rr=%0b iv=%0b pc=%08h cnt=%0d",
                 i, io_rd_Req_ready, io_ar_valid, io_ar_bits_addr, io_r_ready,
                 io_inst_valid, io_inst_bits_pc, io_count);
      end
      if (vecs[i].e_arv && !vecs[i].arr) exp_stall++;
      if (vecs[i].e_iv && vecs[i].ir) exp_fetch++;
      if (vecs[i].rvld && vecs[i].e_rr && !vecs[i].e_iv) exp_drop++;
      @(posedge clock);
      #1;
    end
    idle_inputs();

`ifdef IFU_PERF_CNT_EN
    chk("perf_stall", {32'd0, io_perf_stall}, 64'(exp_stall));
    chk("perf_fetch", {32'd0, io_perf_fetch}, 64'(exp_fetch));
    chk("perf_drop",  {32'd0, io_perf_drop},  64'(exp_drop));
`endif

    // ---------------- stall then asynchronous reset mid-transaction ----------------
    io_ar_ready         = 1'b0;
    io_rd_Req_valid     = 1'b1;
    io_rd_Req_bits_addr = A + 32'h400;
    @(posedge clock);
    #1;
    io_rd_Req_bits_addr = A + 32'h404;
    @(posedge clock);
    #1;
    io_rd_Req_valid = 1'b0;
    waited = 0;
    while (!io_ar_valid && waited < 5) begin
      @(posedge clock);
      #1;
      waited++;
    end
    chk("ar_valid_within_budget", {63'd0, io_ar_valid}, 64'd1);
    chk("stalled_head_addr", {32'd0, io_ar_bits_addr}, {32'd0, A + 32'h400});
    chk("stalled_count", {61'd0, io_count}, 64'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_count", {61'd0, io_count}, 64'd0);
    chk("async_reset_outputs", {61'd0, io_rd_Req_ready, io_ar_valid, io_inst_valid},
        {61'd0, 1'b1, 1'b0, 1'b0});
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    io_ar_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("post_reset_ar_valid", {63'd0, io_ar_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25030077_ifu_fetch_q.md
# ysyx_25030077_ifu_fetch_q

Parametrised instruction-fetch front end that replaces the single-entry IFU request buffer. It accepts PC fetch requests into a DEPTH-entry FIFO and issues them on the AXI-style AR channel, with up to MAX_OUT reads in flight. In-order R responses are paired with their PCs and delivered to the decoder as {pc, inst, err}. A flush (branch redirect) empties the queue and discards the responses of reads already in flight.

## Interface
- ADDR_W, 32, PC / AR address width
- DATA_W, 32, instruction word width
- DEPTH, 4, request FIFO entries (power of 2, ≥2)
- MAX_OUT, 2, max outstanding AR without R (power of 2, ≥1)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- io_rd_Req_valid / io_rd_Req_ready  in / out  1 / 1  request handshake
- io_rd_Req_bits_addr  in  ADDR_W  fetch PC
- io_flush  in  1  redirect pulse; drops queued and in-flight fetches
- io_ar_valid / io_ar_ready  out / in  1 / 1  read-address handshake
- io_ar_bits_addr  out  ADDR_W  read address
- io_r_valid / io_r_ready  in / out  1 / 1  read-data handshake
- io_r_bits_data  in  DATA_W  read data
- io_r_bits_resp  in  2  AXI resp; nonzero = error
- io_inst_valid / io_inst_ready  out / in  1 / 1  instruction handshake to decoder
- io_inst_bits_pc  out  ADDR_W  PC of delivered instruction
- io_inst_bits_data  out  DATA_W  instruction word
- io_inst_bits_err  out  1  access fault flag (resp ≠ 0)
- io_count  out  $clog2(DEPTH)+1  request FIFO occupancy

## Operation
- Request FIFO: circular buffer, wr/rd pointers one bit wider than the index; full = same index, MSB differs. io_rd_Req_ready = !full && !io_flush. Enqueue on valid&&ready.
- AR issue: io_ar_valid = !empty && (outstanding < MAX_OUT) && !io_flush; address = FIFO head. Head pops on AR handshake, and its address is pushed into a MAX_OUT-deep PC tracking FIFO.
- outstanding counter (width $clog2(MAX_OUT)+1): +1 on AR handshake, −1 on R handshake; both in the same cycle = unchanged.
- R path: io_r_ready = io_inst_ready, or 1 when drop_cnt > 0. io_inst_valid = io_r_valid && drop_cnt == 0. io_inst_bits_pc = PC tracking head; data and err are combinational from R. The R handshake pops the PC tracking FIFO.
- Flush, on the cycle io_flush = 1:
  - Request FIFO pointers are cleared.
  - drop_cnt <= outstanding − (R handshake this cycle ? 1 : 0).
  - The PC tracking FIFO is kept so that PCs stay paired with their responses.
  - Each later R handshake with drop_cnt > 0 decrements drop_cnt, pops the PC FIFO, and produces no io_inst_valid.
- Responses arrive in order: exactly one R per AR, no IDs.

## Timing
- Reset outputs: io_rd_Req_ready = 1, io_ar_valid = 0, io_r_ready = io_inst_ready, io_inst_valid = 0, io_count = 0. On reset, pointers, outstanding and drop_cnt all go to 0.
- Reset asserted mid-transaction: all state clears immediately. The memory side is reset on the same net.
- Enqueue to io_ar_valid: 1 cycle (no bypass). Sustained throughput: 1 request/cycle.
- Full FIFO: io_rd_Req_ready = 0 even when an AR pops the head in the same cycle (no pipe-through).
- outstanding == MAX_OUT: io_ar_valid = 0 until an R handshake. The slot frees on the next cycle.
- R to io_inst: 0 cycles (combinational pass-through).
- io_ar_valid, once asserted, holds its address stable until the handshake. The only exception is io_flush, which may withdraw it (permitted; memory is internal).
- Flush and enqueue in the same cycle: the request is rejected (ready = 0).

## Configuration
- IFU_PERF_CNT_EN defined: adds outputs io_perf_fetch (32 b, count of delivered instructions), io_perf_stall (32 b, cycles where io_ar_valid && !io_ar_ready) and io_perf_drop (32 b, count of discarded responses). All reset to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package ysyx_25030077_ifu_pkg holds the AXI_RESP_OKAY constant, the default parameter values, and typedef fetch_pkt_t {pc, data, err}.
- One reusable sub-module, ysyx_25030077_sync_fifo (WIDTH, DEPTH; enq/deq handshakes, clear, count). It is instantiated twice: once as the request FIFO and once as the PC tracking FIFO.

## Test plan
- Reset, then enqueue 0x80000000 with ar_ready = 1: io_ar_valid rises the next cycle with addr 0x80000000. R data 0x00000413, resp 0 → inst pc 0x80000000, data 0x00000413, err 0.
- ar_ready = 0, 5 requests offered at DEPTH = 4: 4 accepted, io_count = 4, 5th ready = 0. Release ar_ready → addresses issued in order.
- MAX_OUT = 2, r_valid held 0: exactly 2 AR handshakes, then io_ar_valid = 0. One R handshake → a 3rd AR is issued the next cycle.
- 2 outstanding plus 2 queued, pulse io_flush, then 2 R responses and a new request 0x80000100: both responses are discarded (io_inst_valid = 0, io_r_ready = 1), io_count = 0 after the flush, and the next delivered pc = 0x80000100.
- R resp = 2'b10 at pc 0x80000004 → io_inst_bits_err = 1.
- io_inst_ready = 0 with r_valid = 1: io_r_ready = 0 and the data is held. With IFU_PERF_CNT_EN, io_perf_stall counts ar back-pressure cycles exactly.
